// File: rtl/adc_multislope.sv
// Multislope run-up ADC controller: integrator reset, signal run-up with
// comparator-steered reference, rundown timing. Optional crossing stats: ADC_STATS_EN.
module adc_multislope #(
  parameter int CW = 24,
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          trig,
  input  logic [CW-1:0] p_clk_count_reset,
  input  logic [CW-1:0] p_clk_count_fix,
  input  logic [AW-1:0] p_clk_count_aperture,
  input  logic [CW-1:0] p_clk_count_rundown_max,
  input  logic          cmpr_val,
  output logic [3:0]    refmux,
  output logic          sigmux,
  output logic          cmpr_latch_ctl,
  output logic          busy,
  output logic          measure_valid,
  output logic          rundown_timeout,
  output logic [AW-1:0] clk_count_mux_sig_last,
  output logic [CW-1:0] count_refmux_pos_up_last,
  output logic [CW-1:0] count_refmux_neg_up_last,
  output logic [CW-1:0] clk_count_rundown_last,
  output logic [CW-1:0] stat_count_cmpr_cross_up_last,
  output logic [7:0]    monitor
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_RESET = 3'd1, S_SIG = 3'd2, S_RUNDOWN = 3'd3, S_DONE = 3'd4
  } state_t;

  localparam logic [3:0] REF_NONE = 4'b0000;
  localparam logic [3:0] REF_POS  = 4'b0001;
  localparam logic [3:0] REF_NEG  = 4'b0010;
  localparam logic [3:0] REF_RST  = 4'b0100;

  state_t        r_state, w_next;
  logic          r_sync1, r_sync2;
  logic [CW-1:0] r_sh_rst, r_sh_fix, r_sh_max;
  logic [AW-1:0] r_sh_ap;
  logic [CW-1:0] r_cnt, r_pos, r_neg, r_rd;
  logic [AW-1:0] r_ap;
  logic [3:0]    r_phase_ref;
  logic          r_sign, r_timeout;
  logic [AW-1:0] r_sig_last;
  logic [CW-1:0] r_pos_last, r_neg_last, r_rd_last;

  logic [AW-1:0] w_ap_inc;
  logic [CW-1:0] w_pos_inc, w_neg_inc, w_rd_inc;
  logic          w_rst_end, w_phase_end, w_ap_done, w_cross, w_rd_max, w_rd_exit;
  logic [2:0]    w_st;

  assign w_ap_inc    = (&r_ap)  ? r_ap  : r_ap  + 1'b1;
  assign w_pos_inc   = (&r_pos) ? r_pos : r_pos + 1'b1;
  assign w_neg_inc   = (&r_neg) ? r_neg : r_neg + 1'b1;
  assign w_rd_inc    = (&r_rd)  ? r_rd  : r_rd  + 1'b1;
  assign w_rst_end   = (r_cnt == r_sh_rst - 1'b1);
  assign w_phase_end = (r_cnt == r_sh_fix - 1'b1);
  assign w_ap_done   = (w_ap_inc >= r_sh_ap);
  assign w_cross     = (r_sync2 != r_sign);
  assign w_rd_max    = (w_rd_inc >= r_sh_max);
  assign w_rd_exit   = (r_state == S_RUNDOWN) && (w_cross || w_rd_max);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_state <= w_next;
      r_sync1 <= cmpr_val;
      r_sync2 <= r_sync1;
    end
  end

  always_comb begin
    w_next         = r_state;
    refmux         = REF_NONE;
    sigmux         = 1'b0;
    cmpr_latch_ctl = 1'b1;
    case (r_state)
      S_IDLE:  if (trig) w_next = S_RESET;
      S_RESET: begin
        refmux         = REF_RST;
        cmpr_latch_ctl = 1'b0;
        if (w_rst_end) w_next = S_SIG;
      end
      S_SIG: begin
        refmux         = r_phase_ref;
        sigmux         = 1'b1;
        cmpr_latch_ctl = 1'b0;
        if (w_phase_end && w_ap_done) w_next = S_RUNDOWN;
      end
      S_RUNDOWN: begin
        refmux         = r_sign ? REF_NEG : REF_POS;
        cmpr_latch_ctl = 1'b0;
        if (w_cross || w_rd_max) w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sh_rst    <= '0;
      r_sh_fix    <= '0;
      r_sh_max    <= '0;
      r_sh_ap     <= '0;
      r_cnt       <= '0;
      r_ap        <= '0;
      r_pos       <= '0;
      r_neg       <= '0;
      r_rd        <= '0;
      r_phase_ref <= REF_NONE;
      r_sign      <= 1'b0;
      r_timeout   <= 1'b0;
      r_sig_last  <= '0;
      r_pos_last  <= '0;
      r_neg_last  <= '0;
      r_rd_last   <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (trig) begin
          // zero-length reset/phase would never terminate; run them as one clock
          r_sh_rst    <= (p_clk_count_reset == '0) ? CW'(1) : p_clk_count_reset;
          r_sh_fix    <= (p_clk_count_fix == '0) ? CW'(1) : p_clk_count_fix;
          r_sh_ap     <= p_clk_count_aperture;
          r_sh_max    <= p_clk_count_rundown_max;
          r_cnt       <= '0;
          r_ap        <= '0;
          r_pos       <= '0;
          r_neg       <= '0;
          r_rd        <= '0;
          r_phase_ref <= REF_NONE;
        end
        S_RESET: r_cnt <= w_rst_end ? '0 : r_cnt + 1'b1;
        S_SIG: begin
          r_ap <= w_ap_inc;
          if (w_phase_end) begin
            r_cnt <= '0;
            if (!w_ap_done) begin
              r_phase_ref <= r_sync2 ? REF_NEG : REF_POS;
              if (r_sync2) r_neg <= w_neg_inc;
              else         r_pos <= w_pos_inc;
            end else begin
              r_sign <= r_sync2;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_RUNDOWN: begin
          r_rd <= w_rd_inc;
          // results land on DONE entry so they are stable while measure_valid is high
          if (w_rd_exit) begin
            r_timeout  <= !w_cross;
            r_sig_last <= r_ap;
            r_pos_last <= r_pos;
            r_neg_last <= r_neg;
            r_rd_last  <= w_rd_inc;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ADC_STATS_EN
  logic          r_cmpr_prev;
  logic [CW-1:0] r_stat, r_stat_last, w_stat_nxt;

  always_comb begin
    w_stat_nxt = r_stat;
    if ((r_state == S_SIG || r_state == S_RUNDOWN) && r_sync2 && !r_cmpr_prev && !(&r_stat))
      w_stat_nxt = r_stat + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cmpr_prev <= 1'b0;
      r_stat      <= '0;
      r_stat_last <= '0;
    end else begin
      r_cmpr_prev <= r_sync2;
      r_stat      <= (r_state == S_IDLE && trig) ? '0 : w_stat_nxt;
      if (w_rd_exit) r_stat_last <= w_stat_nxt;
    end
  end

  assign stat_count_cmpr_cross_up_last = r_stat_last;
`else
  assign stat_count_cmpr_cross_up_last = '0;
`endif

  assign w_st                     = r_state;
  assign busy                     = (r_state != S_IDLE);
  assign measure_valid            = (r_state == S_DONE);
  assign rundown_timeout          = r_timeout;
  assign clk_count_mux_sig_last   = r_sig_last;
  assign count_refmux_pos_up_last = r_pos_last;
  assign count_refmux_neg_up_last = r_neg_last;
  assign clk_count_rundown_last   = r_rd_last;
  assign monitor                  = {w_st, r_sync2, refmux};

endmodule

// File: tb/tb_adc_multislope.sv
// Bench for adc_multislope: per-cycle stimulus tables, conversion timeline
// planned arithmetically from parameters and the comparator table.
module tb_adc_multislope;
  localparam int CW = 24, AW = 32;
  localparam int NCYC = 20000, NA = NCYC + 512;

  typedef struct packed {
    logic [AW-1:0] sig;
    logic [CW-1:0] pos, neg, rd, stat;
    logic          to;
  } last_t;

  logic clk = 1'b0, reset = 1'b0, trig = 1'b0, cmpr_val = 1'b0;
  logic [CW-1:0] p_rst = '0, p_fix = '0, p_max = '0;
  logic [AW-1:0] p_ap = '0;
  logic [3:0] refmux;
  logic sigmux, cmpr_latch_ctl, busy, measure_valid, rundown_timeout;
  logic [AW-1:0] sig_last;
  logic [CW-1:0] pos_last, neg_last, rd_last, stat_last;
  logic [7:0] monitor;

  adc_multislope #(.CW(CW), .AW(AW)) dut (
    .clk(clk), .reset(reset), .trig(trig),
    .p_clk_count_reset(p_rst), .p_clk_count_fix(p_fix),
    .p_clk_count_aperture(p_ap), .p_clk_count_rundown_max(p_max),
    .cmpr_val(cmpr_val), .refmux(refmux), .sigmux(sigmux),
    .cmpr_latch_ctl(cmpr_latch_ctl), .busy(busy), .measure_valid(measure_valid),
    .rundown_timeout(rundown_timeout), .clk_count_mux_sig_last(sig_last),
    .count_refmux_pos_up_last(pos_last), .count_refmux_neg_up_last(neg_last),
    .clk_count_rundown_last(rd_last), .stat_count_cmpr_cross_up_last(stat_last),
    .monitor(monitor));

  always #5 clk = ~clk;

  bit rst_a[NA], trig_a[NA], cmpr_a[NA];
  int pr_a[NA], pf_a[NA], pa_a[NA], pm_a[NA];
  logic [3:0] e_ref[NA];
  bit e_sig[NA], e_lat[NA], e_busy[NA], e_mv[NA], upd[NA];
  last_t upd_v[NA];
  last_t cur;
  int total = 0, bad = 0, cyc = 0, idle_from = 0, mv_cnt = 0;
  bit run_chk = 0;

  function automatic bit sync_at(int c);
    return (c >= 2) ? cmpr_a[c-2] : 1'b0;
  endfunction

  task automatic set_idle(int c);
    e_ref[c] = 4'b0000; e_sig[c] = 0; e_lat[c] = 1; e_busy[c] = 0; e_mv[c] = 0; upd[c] = 0;
  endtask

  task automatic set_exp(int c, logic [3:0] r, bit s, bit l);
    e_ref[c] = r; e_sig[c] = s; e_lat[c] = l; e_busy[c] = 1; e_mv[c] = 0; upd[c] = 0;
  endtask

  // Whole conversion timeline from the trigger cycle: reset, whole phases
  // covering the aperture, then rundown until sign change or limit.
  task automatic plan(int t0);
    int r, f, a, m, n, s0, r0, d, j, npos, nneg, st;
    bit s, cr;
    logic [3:0] ph;
    last_t v;
    r = (pr_a[t0] == 0) ? 1 : pr_a[t0];
    f = (pf_a[t0] == 0) ? 1 : pf_a[t0];
    a = pa_a[t0];
    m = (pm_a[t0] == 0) ? 1 : pm_a[t0];
    n = (a + f - 1) / f;
    if (n == 0) n = 1;
    for (int c = t0 + 1; c <= t0 + r; c++) set_exp(c, 4'b0100, 0, 0);
    s0 = t0 + r + 1;
    npos = 0; nneg = 0;
    for (int k = 0; k < n; k++) begin
      if (k == 0) ph = 4'b0000;
      else if (sync_at(s0 + k*f - 1)) begin ph = 4'b0010; nneg++; end
      else begin ph = 4'b0001; npos++; end
      for (int c = s0 + k*f; c < s0 + (k+1)*f; c++) set_exp(c, ph, 1, 0);
    end
    r0 = s0 + n*f;
    s = sync_at(r0 - 1);
    j = 0; cr = 0;
    while (1) begin
      j++;
      set_exp(r0 + j - 1, s ? 4'b0010 : 4'b0001, 0, 0);
      if (sync_at(r0 + j - 1) != s) begin cr = 1; break; end
      if (j >= m) break;
    end
    d = r0 + j;
    set_exp(d, 4'b0000, 0, 1);
    e_mv[d] = 1;
    st = 0;
    for (int c = s0; c < d; c++) if (sync_at(c) && !sync_at(c-1)) st++;
`ifndef ADC_STATS_EN
    st = 0;
`endif
    v.sig = AW'(n*f); v.pos = CW'(npos); v.neg = CW'(nneg); v.rd = CW'(j);
    v.stat = CW'(st); v.to = !cr;
    upd[d] = 1; upd_v[d] = v;
    idle_from = d + 1;
  endtask

  task automatic chk(string nm, longint act, longint exp);
    total++;
    if (act != exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  always @(negedge clk) if (run_chk) begin
    if (rst_a[cyc]) cur = '0;
    else if (upd[cyc]) cur = upd_v[cyc];
    chk("refmux", refmux, e_ref[cyc]);
    chk("sigmux", sigmux, e_sig[cyc]);
    chk("latch", cmpr_latch_ctl, e_lat[cyc]);
    chk("busy", busy, e_busy[cyc]);
    chk("mvalid", measure_valid, e_mv[cyc]);
    chk("mon_ref", monitor[3:0], e_ref[cyc]);
    chk("mon_sync", monitor[4], sync_at(cyc));
    chk("timeout", rundown_timeout, cur.to);
    chk("sig_last", sig_last, cur.sig);
    chk("pos_last", pos_last, cur.pos);
    chk("neg_last", neg_last, cur.neg);
    chk("rd_last", rd_last, cur.rd);
    chk("stat_last", stat_last, cur.stat);
    if (measure_valid && cyc <= 100) mv_cnt++;
    case (cyc)
      13: chk("lit_rst_ref", refmux, 4'b0100);
      14: begin chk("lit_sig_on", sigmux, 1); chk("lit_sig_ref0", refmux, 0); end
      63: begin
        chk("lit_a_mv", measure_valid, 1); chk("lit_a_sig", sig_last, 40);
        chk("lit_a_pos", pos_last, 3); chk("lit_a_neg", neg_last, 0);
        chk("lit_a_rd", rd_last, 9); chk("lit_a_to", rundown_timeout, 0);
      end
      92: begin
        chk("lit_b_mv", measure_valid, 1); chk("lit_b_sig", sig_last, 5);
        chk("lit_b_rd", rd_last, 20); chk("lit_b_to", rundown_timeout, 1);
      end
      100: chk("lit_mv_pulses", mv_cnt, 2);
      137: chk("lit_c_neg", refmux, 4'b0010);
      138: begin
        chk("lit_c_ref", refmux, 0); chk("lit_c_busy", busy, 0);
        chk("lit_c_sigmux", sigmux, 0); chk("lit_c_sig", sig_last, 0);
        chk("lit_c_rd", rd_last, 0); chk("lit_c_mv", measure_valid, 0);
      end
      174: begin
        chk("lit_d_sig", sig_last, 20); chk("lit_d_pos", pos_last, 2);
        chk("lit_d_neg", neg_last, 1); chk("lit_d_rd", rd_last, 2);
`ifdef ADC_STATS_EN
        chk("lit_d_stat", stat_last, 4);
`else
        chk("lit_d_stat", stat_last, 0);
`endif
      end
      default: ;
    endcase
  end

  task automatic set_par(int lo, int hi, int r, int f, int a, int m);
    for (int c = lo; c <= hi; c++) begin pr_a[c] = r; pf_a[c] = f; pa_a[c] = a; pm_a[c] = m; end
  endtask

  initial begin
    int c, len, r, f, a, m;
    bit v;
    for (int k = 0; k < NA; k++) begin
      set_idle(k); rst_a[k] = 0; trig_a[k] = 0; cmpr_a[k] = 0;
      pr_a[k] = 0; pf_a[k] = 0; pa_a[k] = 0; pm_a[k] = 0;
    end
    // directed: reset, run-up/crossing, timeout, busy/DONE trig, mid-SIG reset, stats
    for (int k = 0; k <= 2; k++) rst_a[k] = 1;
    set_par(0, 10, 3, 10, 35, 100);
    set_par(11, 63, 7, 3, 5, 2);
    set_par(64, 129, 2, 5, 0, 20);
    set_par(130, 149, 1, 4, 30, 50);
    set_par(150, 150, 1, 5, 20, 60);
    set_par(151, 199, 0, 0, 0, 0);
    trig_a[10] = 1; trig_a[30] = 1; trig_a[63] = 1; trig_a[64] = 1;
    trig_a[130] = 1; trig_a[150] = 1;
    rst_a[138] = 1;
    for (int k = 60; k <= 100; k++) cmpr_a[k] = 1;
    for (int k = 120; k <= 134; k++) cmpr_a[k] = 1;
    cmpr_a[152] = 1; cmpr_a[153] = 1; cmpr_a[156] = 1; cmpr_a[157] = 1;
    cmpr_a[160] = 1; cmpr_a[161] = 1;
    for (int k = 164; k <= 170; k++) cmpr_a[k] = 1;
    // randomized region
    c = 200;
    while (c < NCYC) begin
      len = $urandom_range(1, 25); v = $urandom_range(0, 1);
      for (int k = 0; k < len && c < NCYC; k++) begin cmpr_a[c] = v; c++; end
    end
    r = 2; f = 3; a = 20; m = 30;
    for (int k = 200; k < NCYC; k++) begin
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 3))
          0: r = $urandom_range(0, 6);
          1: f = $urandom_range(0, 8);
          2: a = $urandom_range(0, 60);
          default: m = $urandom_range(0, 60);
        endcase
      end
      pr_a[k] = r; pf_a[k] = f; pa_a[k] = a; pm_a[k] = m;
      trig_a[k] = (k < NCYC - 300) && ($urandom_range(0, 15) == 0);
      if (k > 210 && k < NCYC - 300 && $urandom_range(0, 1499) == 0) begin
        rst_a[k] = 1;
        for (int q = k - 3; q <= k + 3; q++) cmpr_a[q] = 0;
      end
    end
    #1 reset = 1;
    for (int k = 0; k < NCYC; k++) begin
      @(posedge clk);
      #1;
      cyc = k;
      reset = rst_a[k]; trig = trig_a[k]; cmpr_val = cmpr_a[k];
      p_rst = CW'(pr_a[k]); p_fix = CW'(pf_a[k]); p_ap = AW'(pa_a[k]); p_max = CW'(pm_a[k]);
      if (rst_a[k]) begin
        for (int q = k; q < k + 400 && q < NA; q++) set_idle(q);
        idle_from = k + 1;
      end else if (trig_a[k] && k >= idle_from) begin
        plan(k);
      end
      run_chk = 1;
    end
    @(posedge clk);
    run_chk = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
